// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory among NUM_REQ clients.
// Grants one requester per cycle and returns its word two edges later with a one-hot tag.
module rom_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic               found;
  logic [PW-1:0]      win;
  int                 idx;

  // Scan from rr_ptr upward, wrapping, and take the first active request.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    if (found) begin
      gnt_d      = NUM_REQ'(1) << win;
      mem_en_d   = 1'b1;
      mem_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
      rr_ptr_d   = (win == PW'(NUM_REQ-1)) ? '0 : win + PW'(1);
    end
    tag_d      = gnt_q;
    rd_valid_d = tag_q;
    rd_data_d  = (|tag_q) ? mem_rdata : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      tag_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a 1-cycle-latency 8x8 ROM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rom_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [11:0] req_addr;
  logic [3:0] gnt;
  logic       mem_en;
  logic [2:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [3:0] rd_valid;
  logic [7:0] rd_data;

  logic [7:0] rom [8];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rom_access_arbiter #(.NUM_REQ(4), .ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_addr(req_addr),
    .gnt(gnt),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  initial begin
    rom[0] = 8'hA1; rom[1] = 8'hB2; rom[2] = 8'hC3; rom[3] = 8'hD4;
    rom[4] = 8'h21; rom[5] = 8'h32; rom[6] = 8'h43; rom[7] = 8'h54;
  end

  initial mem_rdata = 8'h00;
  always @(posedge clk)
    if (mem_en) mem_rdata <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rd", rd_data, 0);

    // 1 single access
    req_addr = {3'd0, 3'd0, 3'd0, 3'd3};
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_en", mem_en, 1);
    chk("t1_addr", mem_addr, 3);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_gnt0", gnt, 0);
    chk("t1_en0", mem_en, 0);
    chk("t1_rv_early", rd_valid, 0);
    @(negedge clk);
    chk("t1_rv", rd_valid, 4'b0001);
    chk("t1_rd", rd_data, 8'hD4);
    @(negedge clk);
    chk("t1_rv0", rd_valid, 0);
    chk("t1_rd_hold", rd_data, 8'hD4);

    // 2 all busy
    do_reset();
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", c), gnt, 4'b0001 << (c % 4));
      chk($sformatf("t2_en%0d", c), mem_en, 1);
      chk($sformatf("t2_addr%0d", c), mem_addr, c % 4);
      if (c >= 2) begin
        chk($sformatf("t2_rv%0d", c), rd_valid, 4'b0001 << ((c - 2) % 4));
        chk($sformatf("t2_rd%0d", c), rd_data, rom[(c - 2) % 4]);
      end else begin
        chk($sformatf("t2_rv%0d", c), rd_valid, 0);
      end
    end

    // 3 fairness
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t3_gnt%0d", c), gnt, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      chk($sformatf("t3_en%0d", c), mem_en, 1);
    end

    // 4 wrap from requester 3 back to 0
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    chk("t4_gnt3", gnt, 4'b1000);
    req = 4'b1001;
    @(negedge clk);
    chk("t4_gnt0", gnt, 4'b0001);
    @(negedge clk);
    chk("t4_gnt3b", gnt, 4'b1000);
    req = 4'b0000;

    // 5 reset mid-flight
    do_reset();
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_en", mem_en, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_rv", rd_valid, 0);
    chk("t5_rd", rd_data, 0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_stale_rv%0d", c), rd_valid, 0);
      chk($sformatf("t5_idle_gnt%0d", c), gnt, 0);
    end
    req = 4'b0110;
    @(negedge clk);
    chk("t5_first", gnt, 4'b0010);
    chk("t5_maddr", mem_addr, 1);
    req = 4'b0000;

    // 6 idle drain then hold
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("t6_gnt%0d", c), gnt, 0);
      chk($sformatf("t6_en%0d", c), mem_en, 0);
      chk($sformatf("t6_rv%0d", c), rd_valid, (c == 1) ? 4'b0010 : 4'b0000);
      chk($sformatf("t6_rd%0d", c), rd_data, (c == 0) ? 8'h00 : 8'hB2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
